// File: rtl/hazard_if.sv
// Signal bundle between the pipeline datapath and the hazard/interlock unit.
// The master side drives pipeline status; the slave side returns stall/flush control.
interface hazard_if;
    logic [4:0]  rs_addr_d;
    logic [4:0]  rt_addr_d;
    logic        branch_d;
    logic        hilo_read_d;
    logic [4:0]  raddr_e;
    logic        reg_write_e;
    logic        mem_read_e;
    logic        muldiv_start_e;
    logic        div_e;
    logic [4:0]  raddr_m;
    logic        mem_read_m;
    logic        mem_stall_m;

    logic        stall_f;
    logic        stall_d;
    logic        stall_e;
    logic        stall_m;
    logic        flush_e;
    logic        flush_m;
    logic        bubble_w;
    logic        muldiv_busy;
    logic        muldiv_done;
    logic [15:0] stall_count;

    modport master (
        output rs_addr_d, rt_addr_d, branch_d, hilo_read_d,
        output raddr_e, reg_write_e, mem_read_e, muldiv_start_e, div_e,
        output raddr_m, mem_read_m, mem_stall_m,
        input  stall_f, stall_d, stall_e, stall_m, flush_e, flush_m, bubble_w,
        input  muldiv_busy, muldiv_done, stall_count
    );

    modport slave (
        input  rs_addr_d, rt_addr_d, branch_d, hilo_read_d,
        input  raddr_e, reg_write_e, mem_read_e, muldiv_start_e, div_e,
        input  raddr_m, mem_read_m, mem_stall_m,
        output stall_f, stall_d, stall_e, stall_m, flush_e, flush_m, bubble_w,
        output muldiv_busy, muldiv_done, stall_count
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline interlock controller: load-use, ID-branch operand, HI/LO busy and
// data-memory wait stalls, plus sequencing of the multi-cycle MULT/DIV unit.
module hazard_unit #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic     clk_i,
    input  logic     rst_i,
    hazard_if.slave  hz
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [15:0]        stall_cnt_q;

    logic lu, br, hl, md;
    logic stall_f, stall_d, stall_e, stall_m, flush_e, flush_m, bubble_w;
    logic start_ok;
    logic [CNT_W-1:0] load_val;

    // Register 0 is hard-wired zero, so it never creates a dependency.
    function automatic logic hit(input logic [4:0] dst, input logic [4:0] rs,
                                 input logic [4:0] rt);
        return (dst != 5'd0) && ((dst == rs) || (dst == rt));
    endfunction

    assign lu = hz.mem_read_e & hz.reg_write_e & hit(hz.raddr_e, hz.rs_addr_d, hz.rt_addr_d);
    assign br = hz.branch_d &
                ((hz.reg_write_e & hit(hz.raddr_e, hz.rs_addr_d, hz.rt_addr_d)) |
                 (hz.mem_read_m  & hit(hz.raddr_m, hz.rs_addr_d, hz.rt_addr_d)));
    assign hl = hz.hilo_read_d & ((state_q == BUSY) | (state_q == DONE));
    assign md = hz.muldiv_start_e & (state_q == BUSY);

    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        bubble_w = 1'b0;
        if (hz.mem_stall_m) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            stall_m  = 1'b1;
            bubble_w = 1'b1;
        end else if (md) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (lu | br | hl) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign start_ok = hz.muldiv_start_e & ~hz.mem_stall_m & ~stall_e;
    assign load_val = hz.div_e ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

    // Busy/done flags are registered alongside the state so they never glitch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state_q <= BUSY;
                        cnt_q   <= load_val;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall_f && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    // Everything is forced low while reset is asserted, including the reset cycle itself.
    assign hz.stall_f     = ~rst_i & stall_f;
    assign hz.stall_d     = ~rst_i & stall_d;
    assign hz.stall_e     = ~rst_i & stall_e;
    assign hz.stall_m     = ~rst_i & stall_m;
    assign hz.flush_e     = ~rst_i & flush_e;
    assign hz.flush_m     = ~rst_i & flush_m;
    assign hz.bubble_w    = ~rst_i & bubble_w;
    assign hz.muldiv_busy = ~rst_i & busy_q;
    assign hz.muldiv_done = ~rst_i & done_q;
    assign hz.stall_count = rst_i ? 16'd0 : stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized and directed bench for hazard_unit against a time-based reference model.
module tb_hazard_unit;
    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_if hz();

    hazard_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: the HI/LO op is described by the cycle numbers in which it is busy and done.
    int cyc = 0;
    int busy_first = -100;
    int busy_last  = -100;
    int done_cyc   = -100;
    int mcount     = 0;

    logic m_busy, m_done;
    logic e_sf, e_sd, e_se, e_sm, e_fe, e_fm, e_bw;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic dep(input logic [4:0] dst);
        return dst != 0 && (dst == hz.rs_addr_d || dst == hz.rt_addr_d);
    endfunction

    task automatic compute_expect();
        logic lu, br, hl, md;
        m_busy = (cyc >= busy_first) && (cyc <= busy_last);
        m_done = (cyc == done_cyc);
        lu = hz.mem_read_e && hz.reg_write_e && dep(hz.raddr_e);
        br = hz.branch_d && ((hz.reg_write_e && dep(hz.raddr_e)) ||
                             (hz.mem_read_m && dep(hz.raddr_m)));
        hl = hz.hilo_read_d && (m_busy || m_done);
        md = hz.muldiv_start_e && m_busy;
        {e_sf, e_sd, e_se, e_sm, e_fe, e_fm, e_bw} = '0;
        if (rst) begin
            // all zero
        end else if (hz.mem_stall_m) begin
            {e_sf, e_sd, e_se, e_sm, e_bw} = 5'b11111;
        end else if (md) begin
            {e_sf, e_sd, e_se, e_fm} = 4'b1111;
        end else if (lu || br || hl) begin
            {e_sf, e_sd, e_fe} = 3'b111;
        end
    endtask

    task automatic cycle();
        int n;
        @(negedge clk);
        compute_expect();
        check_val("stall_f",  {15'd0, hz.stall_f},  {15'd0, e_sf});
        check_val("stall_d",  {15'd0, hz.stall_d},  {15'd0, e_sd});
        check_val("stall_e",  {15'd0, hz.stall_e},  {15'd0, e_se});
        check_val("stall_m",  {15'd0, hz.stall_m},  {15'd0, e_sm});
        check_val("flush_e",  {15'd0, hz.flush_e},  {15'd0, e_fe});
        check_val("flush_m",  {15'd0, hz.flush_m},  {15'd0, e_fm});
        check_val("bubble_w", {15'd0, hz.bubble_w}, {15'd0, e_bw});
        check_val("busy",     {15'd0, hz.muldiv_busy}, {15'd0, (!rst && m_busy)});
        check_val("done",     {15'd0, hz.muldiv_done}, {15'd0, (!rst && m_done)});
        check_val("stall_cnt", hz.stall_count, rst ? 16'd0 : 16'(mcount));
        @(posedge clk);
        if (rst) begin
            busy_first = -100;
            busy_last  = -100;
            done_cyc   = -100;
            mcount     = 0;
        end else begin
            if (e_sf && mcount < 65535) mcount++;
            if (hz.muldiv_start_e && !hz.mem_stall_m && !m_busy) begin
                n = hz.div_e ? DIV_N : MULT_N;
                busy_first = cyc + 1;
                busy_last  = cyc + n;
                done_cyc   = cyc + n + 1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        hz.rs_addr_d = 0; hz.rt_addr_d = 0; hz.branch_d = 0; hz.hilo_read_d = 0;
        hz.raddr_e = 0; hz.reg_write_e = 0; hz.mem_read_e = 0;
        hz.muldiv_start_e = 0; hz.div_e = 0;
        hz.raddr_m = 0; hz.mem_read_m = 0; hz.mem_stall_m = 0;
    endtask

    task automatic random_inputs();
        hz.rs_addr_d      = 5'($urandom_range(0, 3));
        hz.rt_addr_d      = 5'($urandom_range(0, 3));
        hz.raddr_e        = 5'($urandom_range(0, 3));
        hz.raddr_m        = 5'($urandom_range(0, 3));
        hz.branch_d       = ($urandom_range(0, 3) == 0);
        hz.hilo_read_d    = ($urandom_range(0, 3) == 0);
        hz.reg_write_e    = ($urandom_range(0, 1) == 0);
        hz.mem_read_e     = ($urandom_range(0, 3) == 0);
        hz.mem_read_m     = ($urandom_range(0, 3) == 0);
        hz.muldiv_start_e = ($urandom_range(0, 5) == 0);
        hz.div_e          = ($urandom_range(0, 3) == 0);
        hz.mem_stall_m    = ($urandom_range(0, 7) == 0);
        rst               = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // T1 load-use, then the counter must read 1 in the following cycle.
        hz.mem_read_e = 1; hz.reg_write_e = 1; hz.raddr_e = 5; hz.rs_addr_d = 5;
        cycle();
        idle_inputs();
        check_val("t1_cnt", hz.stall_count, 16'd1);

        // T2 register 0 never matches.
        hz.mem_read_e = 1; hz.reg_write_e = 1; hz.raddr_e = 0; hz.rs_addr_d = 0;
        cycle();
        idle_inputs();

        // T3 MULT with MFHI waiting in decode.
        hz.muldiv_start_e = 1;
        cycle();
        hz.muldiv_start_e = 0; hz.hilo_read_d = 1;
        for (int i = 0; i < 7; i++) cycle();
        idle_inputs();

        // T4 DIV with data-memory wait in cycles 3-6.
        hz.muldiv_start_e = 1; hz.div_e = 1;
        cycle();
        idle_inputs();
        for (int i = 1; i < 36; i++) begin
            hz.mem_stall_m = (i >= 3 && i <= 6);
            cycle();
        end
        idle_inputs();

        // T5 back-to-back MULTs: second one waits in E until DONE.
        hz.muldiv_start_e = 1;
        for (int i = 0; i < 12; i++) cycle();
        idle_inputs();
        for (int i = 0; i < 8; i++) cycle();

        // T6 reset in cycle 2 of a DIV aborts it.
        hz.muldiv_start_e = 1; hz.div_e = 1;
        cycle();
        idle_inputs();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_val("t6_busy", {15'd0, hz.muldiv_busy}, 16'd0);
        for (int i = 0; i < 40; i++) cycle();

        for (int i = 0; i < 4000; i++) begin
            random_inputs();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
